// File: rtl/loader_pkg.sv
// Shared types and constants for the serial instruction loader.
// Latency: n/a (definitions only).
// Backpressure: n/a. CSUM exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    // Number of bytes in the word-count header and in each instruction word
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int WORD_BITS  = WORD_BYTES * 8;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        LOAD,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_e;

    // States in which the loader consumes bytes from the stream
    function automatic logic accepts_bytes(input state_e s);
`ifdef LOADER_CHECKSUM_EN
        return (s == HDR0) || (s == HDR1) || (s == LOAD) || (s == CSUM);
`else
        return (s == HDR0) || (s == HDR1) || (s == LOAD);
`endif
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: header count N, N little-endian words written to core imem.
// Latency: dbg_wr_en pulses the cycle after the 4th byte of a word is accepted; all outputs registered.
// Backpressure: in_ready drops for the WRITE cycle and in DONE/ERROR; bytes move only on in_valid & in_ready.
//
// Ports:
//   clk, rst (async, active low)
//   in_valid/in_data/in_ready : byte stream in
//   start                     : reload request, honoured only in DONE or ERROR
//   dbg_wr_en/dbg_addr/dbg_instr : instruction-memory write port into the core
//   cpu_rst                   : core reset, high until the load completes
//   err                       : checksum failure (always 0 unless LOADER_CHECKSUM_EN)
// Build option: define LOADER_CHECKSUM_EN to add the trailing XOR checksum byte and CSUM state.
module instr_loader
    import loader_pkg::*;
#(
    parameter int                            XLEN               = 64,
    parameter int                            INSTRUCTION_LENGTH = XLEN / 2,
    parameter logic [INSTRUCTION_LENGTH-1:0] BASE_ADDR          = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    input  logic                          start,
    output logic                          dbg_wr_en,
    output logic [INSTRUCTION_LENGTH-1:0] dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
    output logic                          cpu_rst,
    output logic                          err
);

    localparam int IL = INSTRUCTION_LENGTH;
    localparam int CW = HDR_BYTES * 8;

    // Where the FSM goes once the payload (or an empty header) is finished
`ifdef LOADER_CHECKSUM_EN
    localparam state_e AFTER_PAYLOAD = CSUM;
`else
    localparam state_e AFTER_PAYLOAD = DONE;
`endif

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;            // words still to be written
    logic [1:0]        byte_cnt_q, byte_cnt_d;  // byte position inside the current word
    logic [WORD_BITS-1:0] word_q, word_d;       // word being assembled
    logic [IL-1:0]     addr_q, addr_d;          // address of the next write

    logic              in_ready_q;
    logic              dbg_wr_en_q;
    logic [IL-1:0]     dbg_addr_q;
    logic [IL-1:0]     dbg_instr_q;
    logic              cpu_rst_q;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              err_q;
`endif

    logic accept;
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        // Every accepted byte except the checksum itself joins the running XOR
        if (accept && (state_q != CSUM)) begin
            csum_d = csum_q ^ in_data;
        end
`endif

        case (state_q)
            HDR0: begin
                if (accept) begin
                    cnt_d[7:0] = in_data;
                    state_d    = HDR1;
                end
            end

            HDR1: begin
                if (accept) begin
                    cnt_d[15:8] = in_data;
                    if ({in_data, cnt_q[7:0]} == 16'd0) begin
                        state_d = AFTER_PAYLOAD;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                if (accept) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'(WORD_BYTES - 1)) begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                // The write itself is issued by the output registers; here we
                // only step past it. Address wraps naturally at IL bits.
                addr_d = addr_q + IL'(4);
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = AFTER_PAYLOAD;
                end else begin
                    state_d = LOAD;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERROR;
                end
            end
`endif

            DONE, ERROR: begin
                if (start) begin
                    state_d    = HDR0;
                    addr_d     = BASE_ADDR;
                    cnt_d      = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end

            default: begin
                state_d = HDR0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // they describe without any combinational path to the ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HDR0;
            cnt_q       <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            addr_q      <= BASE_ADDR;
            in_ready_q  <= 1'b1;
            dbg_wr_en_q <= 1'b0;
            dbg_addr_q  <= BASE_ADDR;
            dbg_instr_q <= '0;
            cpu_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            in_ready_q  <= accepts_bytes(state_d);
            dbg_wr_en_q <= (state_d == WRITE);
            cpu_rst_q   <= (state_d != DONE);
            // Only entering WRITE updates the write port; it holds otherwise
            if (state_d == WRITE) begin
                dbg_addr_q  <= addr_d;
                dbg_instr_q <= IL'(word_d);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= (state_d == ERROR);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign dbg_wr_en = dbg_wr_en_q;
    assign dbg_addr  = dbg_addr_q;
    assign dbg_instr = dbg_instr_q;
    assign cpu_rst   = cpu_rst_q;

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
module tb_instr_loader;

    localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFFC;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        start;

    logic        in_ready,  in_ready_w;
    logic        dbg_wr_en, dbg_wr_en_w;
    logic [31:0] dbg_addr,  dbg_addr_w;
    logic [31:0] dbg_instr, dbg_instr_w;
    logic        cpu_rst,   cpu_rst_w;
    logic        err,       err_w;

    // Two loaders share one input stream; they differ only in BASE_ADDR
    instr_loader #(.XLEN(64), .INSTRUCTION_LENGTH(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .start(start), .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
        .cpu_rst(cpu_rst), .err(err)
    );

    instr_loader #(.XLEN(64), .INSTRUCTION_LENGTH(32), .BASE_ADDR(WRAP_BASE)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w),
        .start(start), .dbg_wr_en(dbg_wr_en_w), .dbg_addr(dbg_addr_w), .dbg_instr(dbg_instr_w),
        .cpu_rst(cpu_rst_w), .err(err_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- write monitor ----------------
    logic [63:0] wq[$];
    logic [63:0] wq_w[$];
    int          wr_cyc[$];
    int          rdy_bad = 0;
    int          wr_run = 0;
    int          wr_run_max = 0;

    always @(negedge clk) begin
        if (dbg_wr_en) begin
            wq.push_back({dbg_addr, dbg_instr});
            wr_cyc.push_back(cyc);
            if (in_ready) rdy_bad++;
            wr_run++;
            if (wr_run > wr_run_max) wr_run_max = wr_run;
        end else begin
            wr_run = 0;
        end
        if (dbg_wr_en_w) wq_w.push_back({dbg_addr_w, dbg_instr_w});
    end

    task automatic clear_mon();
        wq.delete();
        wq_w.delete();
        wr_cyc.delete();
        rdy_bad    = 0;
        wr_run_max = 0;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] words[$];
    logic [7:0]  stream[$];
    logic [63:0] exp_wr[$];
    logic [63:0] exp_wr_w[$];
    int          last_acc_cyc;

    // Image format: N (16-bit LE), N words (LE), optional XOR of everything before
    task automatic build_stream(input bit bad_csum);
        logic [15:0] n;
        logic [7:0]  x;
        stream.delete();
        exp_wr.delete();
        exp_wr_w.delete();
        n = 16'(words.size());
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) stream.push_back(words[i][8*b +: 8]);
            exp_wr.push_back({32'(4 * i), words[i]});
            exp_wr_w.push_back({WRAP_BASE + 32'(4 * i), words[i]});
        end
        if (CSUM_EN) begin
            x = 8'h00;
            foreach (stream[i]) x = x ^ stream[i];
            stream.push_back(bad_csum ? (x ^ 8'h01) : x);
        end
    endtask

    // ---------------- drivers (entered and left on a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit done = 1'b0;
        bit acc;
        int budget = 100;
        while (!done && budget > 0) begin
            in_data  = b;
            in_valid = ($urandom_range(99) >= gap_pct);
            acc      = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                done = 1'b1;
                last_acc_cyc = cyc;
            end
            budget--;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout byte %h never accepted (in_ready %b, want 1)", b, in_ready);
        end
    endtask

    task automatic wait_end();
        int budget = 50;
        while (cpu_rst !== 1'b0 && err !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (2) @(negedge clk);
        if (budget == 0) begin
            checks++; errors++;
            $display("FAIL wait_end_timeout cpu_rst %b err %b, want cpu_rst 0 or err 1", cpu_rst, err);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || cpu_rst !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_restart got rdy/cpu_rst/err %b%b%b want 110", in_ready, cpu_rst, err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (dbg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", dbg_wr_en); end
        checks++; if (dbg_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", dbg_addr); end
        checks++; if (dbg_addr_w !== WRAP_BASE) begin errors++; $display("FAIL reset_addr_w got %h want %h", dbg_addr_w, WRAP_BASE); end
        checks++; if (dbg_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", dbg_instr); end
        checks++; if (cpu_rst !== 1'b1)   begin errors++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word(input int gap_pct, input string tag);
        int k_cyc;
        words.delete();
        words.push_back(32'h0020_B0B7);
        build_stream(1'b0);
        clear_mon();
        foreach (stream[i]) begin
            send_byte(stream[i], gap_pct);
            if (i == 5) k_cyc = last_acc_cyc;
        end
        wait_end();
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL %s_wr_count got %0d want 1", tag, wq.size()); end
        checks++; if (wq[0] !== {32'h0, 32'h0020_B0B7}) begin errors++; $display("FAIL %s_write got %h want 000000000020b0b7", tag, wq[0]); end
        checks++; if (wr_cyc[0] != k_cyc) begin errors++; $display("FAIL %s_wr_timing got cycle %0d want %0d", tag, wr_cyc[0], k_cyc); end
        checks++; if (wr_run_max != 1) begin errors++; $display("FAIL %s_wr_pulse_len got %0d want 1", tag, wr_run_max); end
        checks++; if (rdy_bad != 0) begin errors++; $display("FAIL %s_rdy_in_write got %0d high cycles want 0", tag, rdy_bad); end
        checks++; if (cpu_rst !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL %s_done got cpu_rst %b err %b want 0 0", tag, cpu_rst, err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_done_rdy got %b want 0", tag, in_ready); end
    endtask

    task automatic test_zero_count();
        words.delete();
        build_stream(1'b0);
        clear_mon();
        foreach (stream[i]) send_byte(stream[i], 30);
        wait_end();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL zero_wr_count got %0d want 0", wq.size()); end
        checks++; if (cpu_rst !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL zero_done got cpu_rst %b err %b want 0 0", cpu_rst, err); end
    endtask

    task automatic test_wrap();
        words.delete();
        words.push_back($urandom());
        words.push_back($urandom());
        build_stream(1'b0);
        clear_mon();
        foreach (stream[i]) send_byte(stream[i], 20);
        wait_end();
        checks++; if (wq_w.size() != 2) begin errors++; $display("FAIL wrap_wr_count got %0d want 2", wq_w.size()); end
        checks++; if (wq_w[0] !== {32'hFFFF_FFFC, words[0]}) begin errors++; $display("FAIL wrap_first got %h want %h", wq_w[0], {32'hFFFF_FFFC, words[0]}); end
        checks++; if (wq_w[1] !== {32'h0000_0000, words[1]}) begin errors++; $display("FAIL wrap_second got %h want %h", wq_w[1], {32'h0, words[1]}); end
        checks++; if (wq.size() != 2 || wq[1] !== {32'h4, words[1]}) begin errors++; $display("FAIL wrap_base0_second got %h want %h", wq[1], {32'h4, words[1]}); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_csum_mismatch();
        words.delete();
        words.push_back(32'h0020_B0B7);
        build_stream(1'b1);
        clear_mon();
        foreach (stream[i]) send_byte(stream[i], 0);
        wait_end();
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL csum_err got %b want 1", err); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL csum_cpu_rst got %b want 1", cpu_rst); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL csum_rdy got %b want 0", in_ready); end
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL csum_wr_count got %0d want 1", wq.size()); end
        do_start();
    endtask
`endif

    task automatic test_random_loads();
        for (int r = 0; r < 6; r++) begin
            int n   = $urandom_range(1, 5);
            int gap = $urandom_range(0, 60);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom());
            build_stream(1'b0);
            clear_mon();
            foreach (stream[i]) begin
                // A start mid-load must be ignored
                if (r == 1 && i == 3) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                send_byte(stream[i], gap);
            end
            wait_end();
            checks++;
            if (wq.size() != exp_wr.size() || wq_w.size() != exp_wr_w.size()) begin
                errors++;
                $display("FAIL rand%0d_wr_count got %0d/%0d want %0d", r, wq.size(), wq_w.size(), exp_wr.size());
            end else begin
                foreach (exp_wr[i]) begin
                    checks++;
                    if (wq[i] !== exp_wr[i] || wq_w[i] !== exp_wr_w[i]) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d got %h/%h want %h/%h", r, i, wq[i], wq_w[i], exp_wr[i], exp_wr_w[i]);
                    end
                end
            end
            checks++; if (cpu_rst !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rand%0d_done got cpu_rst %b err %b want 0 0", r, cpu_rst, err); end
            do_start();
        end
    endtask

    task automatic test_reset_mid_load();
        words.delete();
        words.push_back(32'h0020_B0B7);
        build_stream(1'b0);
        clear_mon();
        for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wq.size() != 0 || wq_w.size() != 0) begin errors++; $display("FAIL rstmid_wr_count got %0d want 0", wq.size()); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_rdy got %b want 1", in_ready); end
        checks++; if (dbg_addr !== 32'h0 || dbg_addr_w !== WRAP_BASE) begin errors++; $display("FAIL rstmid_addr got %h/%h want 0/%h", dbg_addr, dbg_addr_w, WRAP_BASE); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rstmid_cpu_rst got %b want 1", cpu_rst); end
        // A fresh image afterwards must assemble from byte 0 again
        test_single_word(40, "after_rst");
    endtask

    initial begin
        test_reset();
        test_single_word(0, "single");
        do_start();
        test_single_word(50, "gaps");
        do_start();
        test_zero_count();
        do_start();
        test_wrap();
        do_start();
`ifdef LOADER_CHECKSUM_EN
        test_csum_mismatch();
`endif
        test_random_loads();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

endmodule
